// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, reads instruction memory with a
// ready handshake and holds each word for decode until it is accepted.
module instr_fetch #(
  parameter int unsigned          WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic                 mem_ready,
  input  logic [WORD_SIZE-1:0] mem_data,
  output logic [WORD_SIZE-1:0] instr,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 instr_valid,
  input  logic                 instr_accept,
  input  logic                 branch,
  input  logic [WORD_SIZE-1:0] branch_target,
  input  logic                 halt
);

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic                 mem_req_q;
  logic                 instr_valid_q;

  // State register; mem_req/instr_valid are flopped from the next state so
  // they track the state exactly without any input-to-output path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_START;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= (state_d == ST_FETCH);
      instr_valid_q <= (state_d == ST_HOLD);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      instr_q    <= '0;
      pc_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

  // Next state and datapath; halt outranks branch, branch outranks progress.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;

    case (state_q)
      ST_START: begin
        if (halt) state_d = ST_HALTED;
        else      state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else if (branch) begin
          // A coincident mem_ready is dropped; the redirect restarts the read.
          fetch_pc_d = branch_target;
        end else if (mem_ready) begin
          instr_d    = mem_data;
          pc_d       = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + WORD_SIZE'(1);
          state_d    = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else if (branch) begin
          fetch_pc_d = branch_target;
          state_d    = ST_FETCH;
        end else if (instr_accept) begin
          state_d = ST_FETCH;
        end
      end

      ST_HALTED: begin
        state_d = ST_HALTED;
      end

      default: begin
        state_d = ST_START;
      end
    endcase
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = fetch_pc_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand sequences for stalls,
// wait states and halt/reset, then random traffic against a reference model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic [15:0] pc;
  logic        instr_valid;
  logic        instr_accept;
  logic        branch;
  logic [15:0] branch_target;
  logic        halt;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_data      (mem_data),
    .instr         (instr),
    .pc            (pc),
    .instr_valid   (instr_valid),
    .instr_accept  (instr_accept),
    .branch        (branch),
    .branch_target (branch_target),
    .halt          (halt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        accept;
    logic        br;
    logic [15:0] target;
    logic        hlt;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_instr;
    logic [15:0] exp_pc;
  } vec_t;

  // Reference model state, expressed in terms of what the stage is doing.
  bit          m_started, m_halted, m_holding;
  logic [15:0] m_fpc, m_instr, m_pc;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic er, input logic [15:0] ea,
                           input logic ev, input logic [15:0] ei, input logic [15:0] ep);
    check($sformatf("%s.mem_req", tag), 16'(mem_req), 16'(er));
    check($sformatf("%s.mem_addr", tag), mem_addr, ea);
    check($sformatf("%s.instr_valid", tag), 16'(instr_valid), 16'(ev));
    check($sformatf("%s.instr", tag), instr, ei);
    check($sformatf("%s.pc", tag), pc, ep);
  endtask

  task automatic idle_inputs();
    mem_ready = 1'b0; instr_accept = 1'b0; branch = 1'b0;
    branch_target = 16'h0000; halt = 1'b0; mem_data = 16'h0000;
  endtask

  // Assert reset at a negedge, check the asynchronous clear, release at the next negedge.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all(tag, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic model_reset();
    m_started = 0; m_halted = 0; m_holding = 0;
    m_fpc = 16'h0000; m_instr = 16'h0000; m_pc = 16'h0000;
  endtask

  task automatic model_step(input logic rdy, input logic acc, input logic br,
                            input logic [15:0] tgt, input logic hlt, input logic [15:0] data);
    if (m_halted) return;
    if (!m_started) begin
      m_started = 1;
      if (hlt) m_halted = 1;
    end else if (hlt) begin
      m_halted = 1; m_holding = 0;
    end else if (br) begin
      m_fpc = tgt; m_holding = 0;
    end else if (m_holding) begin
      if (acc) m_holding = 0;
    end else if (rdy) begin
      m_instr = data; m_pc = m_fpc; m_fpc = 16'((int'(m_fpc) + 1) % 65536); m_holding = 1;
    end
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[15];
    logic [15:0] base;

    vecs[0]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,16'h0000,1'b0,16'h0000,16'h0000};
    vecs[1]  = '{1'b1,1'b1,1'b0,16'h0000,1'b0, 1'b0,16'h0001,1'b1,16'hA500,16'h0000};
    vecs[2]  = '{1'b1,1'b1,1'b0,16'h0000,1'b0, 1'b1,16'h0001,1'b0,16'hA500,16'h0000};
    vecs[3]  = '{1'b1,1'b1,1'b0,16'h0000,1'b0, 1'b0,16'h0002,1'b1,16'hA501,16'h0001};
    vecs[4]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,16'h0002,1'b1,16'hA501,16'h0001};
    vecs[5]  = '{1'b0,1'b1,1'b0,16'h0000,1'b0, 1'b1,16'h0002,1'b0,16'hA501,16'h0001};
    vecs[6]  = '{1'b0,1'b1,1'b0,16'h0000,1'b0, 1'b1,16'h0002,1'b0,16'hA501,16'h0001};
    vecs[7]  = '{1'b1,1'b0,1'b1,16'h0040,1'b0, 1'b1,16'h0040,1'b0,16'hA501,16'h0001};
    vecs[8]  = '{1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b0,16'h0041,1'b1,16'hA540,16'h0040};
    vecs[9]  = '{1'b0,1'b1,1'b1,16'hFFFF,1'b0, 1'b1,16'hFFFF,1'b0,16'hA540,16'h0040};
    vecs[10] = '{1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b0,16'h0000,1'b1,16'h5AFF,16'hFFFF};
    vecs[11] = '{1'b0,1'b1,1'b0,16'h0000,1'b0, 1'b1,16'h0000,1'b0,16'h5AFF,16'hFFFF};
    vecs[12] = '{1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b0,16'h0001,1'b1,16'hA500,16'h0000};
    vecs[13] = '{1'b0,1'b1,1'b0,16'h0000,1'b1, 1'b0,16'h0001,1'b0,16'hA500,16'h0000};
    vecs[14] = '{1'b1,1'b1,1'b1,16'h1234,1'b0, 1'b0,16'h0001,1'b0,16'hA500,16'h0000};

    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Directed table: memory returns addr ^ 16'hA500.
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      mem_data      = mem_addr ^ 16'hA500;
      mem_ready     = vecs[i].ready;
      instr_accept  = vecs[i].accept;
      branch        = vecs[i].br;
      branch_target = vecs[i].target;
      halt          = vecs[i].hlt;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                vecs[i].exp_valid, vecs[i].exp_instr, vecs[i].exp_pc);
    end

    // Reset out of HALTED: START for one edge, then fetch from RESET_PC.
    @(negedge clk);
    idle_inputs();
    reset_pulse("rst_halted");
    #1;
    check_all("start", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    check_all("first_req", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);

    // Decode stall: 5 cycles without accept keep instr/pc frozen and no request.
    @(negedge clk);
    mem_ready = 1'b1; mem_data = 16'h1234; instr_accept = 1'b0;
    @(posedge clk);
    #1;
    check_all("stall_latch", 1'b0, 16'h0001, 1'b1, 16'h1234, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1)); mem_data = 16'($urandom);
      @(posedge clk);
      #1;
      check_all($sformatf("stall%0d", k), 1'b0, 16'h0001, 1'b1, 16'h1234, 16'h0000);
    end
    @(negedge clk);
    mem_ready = 1'b0; instr_accept = 1'b1;
    @(posedge clk);
    #1;
    check_all("stall_resume", 1'b1, 16'h0001, 1'b0, 16'h1234, 16'h0000);

    // Wait states: ready only on every 3rd FETCH cycle.
    base = 16'h0001;
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 3; w++) begin
        @(negedge clk);
        mem_ready = (w == 2); instr_accept = 1'b1; mem_data = mem_addr ^ 16'hA500;
        @(posedge clk);
        #1;
        if (w == 2)
          check_all($sformatf("ws%0d_%0d", f, w), 1'b0, 16'(base + 16'(f) + 16'd1), 1'b1,
                    16'(base + 16'(f)) ^ 16'hA500, 16'(base + 16'(f)));
        else
          check($sformatf("ws%0d_%0d.addr_hold", f, w), {mem_addr[15:1], mem_req},
                {16'(base + 16'(f)) >> 1, 1'b1} | 16'(0));
      end
      @(negedge clk);
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("ws%0d.refetch", f), 16'(mem_req), 16'h0001);
      check($sformatf("ws%0d.addr", f), mem_addr, 16'(base + 16'(f) + 16'd1));
    end

    // Halt in FETCH with coincident branch and ready: nothing latched, stays idle.
    @(negedge clk);
    halt = 1'b1; branch = 1'b1; branch_target = 16'h0777; mem_ready = 1'b1; mem_data = 16'hBEEF;
    @(posedge clk);
    #1;
    check_all("halt_fetch", 1'b0, 16'h0004, 1'b0, 16'h0003 ^ 16'hA500, 16'h0003);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      halt = 1'b0; branch = 1'($urandom_range(0, 1)); branch_target = 16'($urandom);
      mem_ready = 1'b1; instr_accept = 1'b1;
      @(posedge clk);
      #1;
      check_all($sformatf("halted%0d", k), 1'b0, 16'h0004, 1'b0, 16'h0003 ^ 16'hA500, 16'h0003);
    end
    @(negedge clk);
    idle_inputs();
    reset_pulse("rst_after_halt");
    @(posedge clk);
    #1;
    check_all("restart", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);

    // Random traffic against the reference model, with occasional resets.
    @(negedge clk);
    idle_inputs();
    reset_pulse("rst_rand");
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic rdy, acc, br, hlt;
      logic [15:0] tgt, data;
      if (i > 0) @(negedge clk);
      if ((m_halted && $urandom_range(0, 9) == 0) || $urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_all($sformatf("rand_rst%0d", i), 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        continue;
      end
      reset = 1'b0;
      rdy  = ($urandom_range(0, 99) < 50);
      acc  = ($urandom_range(0, 99) < 60);
      br   = m_started && ($urandom_range(0, 99) < 6);
      tgt  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      hlt  = ($urandom_range(0, 149) == 0);
      data = 16'($urandom);
      mem_ready = rdy; instr_accept = acc; branch = br; branch_target = tgt;
      halt = hlt; mem_data = data;
      @(posedge clk);
      #1;
      model_step(rdy, acc, br, tgt, hlt, data);
      check_all($sformatf("rand%0d", i), m_started && !m_halted && !m_holding, m_fpc,
                m_holding, m_instr, m_pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
